// File: rtl/data_parity_filter_pkg.sv
// Shared constants, types and the byte classifier for data_parity_filter_axis.
// DATA_PARITY_FILTER_LSB_MODE_EN selects tdata[0] classification instead of bit-XOR parity.
package data_parity_filter_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  function automatic logic is_odd(input data_t d);
`ifdef DATA_PARITY_FILTER_LSB_MODE_EN
    return d[0];
`else
    return ^d;
`endif
  endfunction

endpackage

// File: rtl/data_parity_filter_axis_buffer.sv
// Per-class packet buffer: 8x8 storage, write count, read pointer and AXIS valid/last.
// Classification (and DATA_PARITY_FILTER_LSB_MODE_EN) lives upstream in the top.
module parity_buffer
  import data_parity_filter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  data_t wr_data,
  input  logic  clear,
  input  logic  drain_en,
  input  logic  rd_ready,
  output logic  fill_o,
  output logic  tvalid_o,
  output data_t tdata_o,
  output logic  tlast_o,
  output logic  done_o
);

  localparam cnt_t LAST_SLOT = cnt_t'(DEPTH - 1);

  data_t mem_q [DEPTH];
  data_t mem_d [DEPTH];
  cnt_t  count_q, count_d;
  cnt_t  rd_ptr_q, rd_ptr_d;
  logic  rd_fire;

  always_comb begin
    tvalid_o = drain_en && (rd_ptr_q < count_q);
    tdata_o  = tvalid_o ? mem_q[rd_ptr_q[IDX_W-1:0]] : '0;
    tlast_o  = tvalid_o && (rd_ptr_q == count_q - cnt_t'(1));
    rd_fire  = tvalid_o && rd_ready;
    // Done covers both an empty class and the final beat handshaking this cycle.
    done_o   = drain_en && ((rd_ptr_q == count_q) || (rd_fire && tlast_o));
    fill_o   = wr_en && (count_q == LAST_SLOT);

    mem_d    = mem_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      count_d  = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[count_q[IDX_W-1:0]] = wr_data;
        count_d = count_q + cnt_t'(1);
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/data_parity_filter_axis.sv
// Splits one AXIS byte stream into odd/even parity streams, one segment at a time.
// DATA_PARITY_FILTER_LSB_MODE_EN (package) switches classification to tdata[0].
module data_parity_filter_axis
  import data_parity_filter_pkg::*;
(
  input  logic              a_clk,
  input  logic              axis_aresetn,
  input  logic              axis_s_tvalid,
  input  logic [DATA_W-1:0] axis_s_tdata,
  input  logic              axis_s_tlast,
  output logic              axis_s_tready,
  input  logic              axis_m_tready,
  output logic              axis_m_tvalid_odd,
  output logic [DATA_W-1:0] axis_m_tdata_odd,
  output logic              axis_m_tlast_odd,
  output logic              axis_m_tvalid_even,
  output logic [DATA_W-1:0] axis_m_tdata_even,
  output logic              axis_m_tlast_even
);

  state_t state_q, state_d;
  logic   s_tready_q, s_tready_d;
  logic   beat_acc, beat_odd, wr_odd, wr_even;
  logic   fill_odd, fill_even, done_odd, done_even;
  logic   seg_end, clear, drain_en;

  always_comb begin
    beat_acc = axis_s_tvalid && s_tready_q;
    beat_odd = is_odd(axis_s_tdata);
    wr_odd   = beat_acc && beat_odd;
    wr_even  = beat_acc && !beat_odd;
    seg_end  = beat_acc && (axis_s_tlast || fill_odd || fill_even);
    drain_en = (state_q == DRAIN);
    clear    = drain_en && done_odd && done_even;

    state_d = state_q;
    if (state_q == COLLECT) begin
      if (seg_end) state_d = DRAIN;
    end else begin
      if (clear) state_d = COLLECT;
    end
    // Ready is registered so it stays low throughout reset and rises on the first edge after.
    s_tready_d = (state_d == COLLECT);
  end

  always_ff @(posedge a_clk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      state_q    <= COLLECT;
      s_tready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_tready_q <= s_tready_d;
    end
  end

  assign axis_s_tready = s_tready_q;

  parity_buffer u_odd (
    .clk      (a_clk),
    .rst      (axis_aresetn),
    .wr_en    (wr_odd),
    .wr_data  (axis_s_tdata),
    .clear    (clear),
    .drain_en (drain_en),
    .rd_ready (axis_m_tready),
    .fill_o   (fill_odd),
    .tvalid_o (axis_m_tvalid_odd),
    .tdata_o  (axis_m_tdata_odd),
    .tlast_o  (axis_m_tlast_odd),
    .done_o   (done_odd)
  );

  parity_buffer u_even (
    .clk      (a_clk),
    .rst      (axis_aresetn),
    .wr_en    (wr_even),
    .wr_data  (axis_s_tdata),
    .clear    (clear),
    .drain_en (drain_en),
    .rd_ready (axis_m_tready),
    .fill_o   (fill_even),
    .tvalid_o (axis_m_tvalid_even),
    .tdata_o  (axis_m_tdata_even),
    .tlast_o  (axis_m_tlast_even),
    .done_o   (done_even)
  );

endmodule

// File: tb/tb_data_parity_filter_axis.sv
// Directed self-checking bench for data_parity_filter_axis; expectations follow
// DATA_PARITY_FILTER_LSB_MODE_EN where classification differs.
module tb_data_parity_filter_axis;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tvalid = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       m_tready = 1'b0;
  logic       tvo, tlo, tve, tle;
  logic [7:0] tdo, tde;

  always #5 clk = ~clk;

  data_parity_filter_axis dut (
    .a_clk              (clk),
    .axis_aresetn       (rst),
    .axis_s_tvalid      (s_tvalid),
    .axis_s_tdata       (s_tdata),
    .axis_s_tlast       (s_tlast),
    .axis_s_tready      (s_tready),
    .axis_m_tready      (m_tready),
    .axis_m_tvalid_odd  (tvo),
    .axis_m_tdata_odd   (tdo),
    .axis_m_tlast_odd   (tlo),
    .axis_m_tvalid_even (tve),
    .axis_m_tdata_even  (tde),
    .axis_m_tlast_even  (tle)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [8:0] q_odd[$], q_even[$];
  logic [8:0] exp_odd[$], exp_even[$];
  int         base_odd = 0, base_even = 0;

  int unsigned viol_rdy = 0, viol_zero = 0, viol_hold = 0;
  logic        prev_vo = 1'b0, prev_ve = 1'b0, prev_rdy = 1'b0;
  logic [8:0]  prev_o = '0, prev_e = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake recorder and protocol watchdog, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_vo <= 1'b0;
      prev_ve <= 1'b0;
    end else begin
      if (s_tready && (tvo || tve)) viol_rdy <= viol_rdy + 1;
      if ((!tvo && (tdo != 8'h00 || tlo)) || (!tve && (tde != 8'h00 || tle)))
        viol_zero <= viol_zero + 1;
      if ((prev_vo && !prev_rdy && (!tvo || {tlo, tdo} != prev_o)) ||
          (prev_ve && !prev_rdy && (!tve || {tle, tde} != prev_e)))
        viol_hold <= viol_hold + 1;
      if (tvo && m_tready) q_odd.push_back({tlo, tdo});
      if (tve && m_tready) q_even.push_back({tle, tde});
      prev_vo  <= tvo;
      prev_ve  <= tve;
      prev_o   <= {tlo, tdo};
      prev_e   <= {tle, tde};
      prev_rdy <= m_tready;
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    int unsigned w = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    while (!s_tready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("send_ready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned w = 0;
    while (!(s_tready && !tvo && !tve) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_idle"}, 32'({s_tready, tvo, tve}), 32'b100);
  endtask

  task automatic verify(input string tag);
    check({tag, "_odd_n"}, 32'(q_odd.size() - base_odd), 32'(exp_odd.size()));
    for (int i = 0; i < exp_odd.size(); i++)
      if (base_odd + i < q_odd.size())
        check({tag, "_odd_beat"}, 32'(q_odd[base_odd + i]), 32'(exp_odd[i]));
    check({tag, "_even_n"}, 32'(q_even.size() - base_even), 32'(exp_even.size()));
    for (int i = 0; i < exp_even.size(); i++)
      if (base_even + i < q_even.size())
        check({tag, "_even_beat"}, 32'(q_even[base_even + i]), 32'(exp_even[i]));
    base_odd  = q_odd.size();
    base_even = q_even.size();
    exp_odd.delete();
    exp_even.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_valid", 32'({tvo, tve, tlo, tle}), 32'd0);
    check("rst_data", 32'({tdo, tde}), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(s_tready), 32'd1);

    // Mixed packet, simultaneous completion
    m_tready = 1'b1;
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    send(8'h07, 1'b0);
    send(8'h00, 1'b1);
    check("t1_lat_valid", 32'({tvo, tve}), 32'b11);
    check("t1_beat0_data", 32'({tdo, tde}), 32'h0103);
    check("t1_drain_ready", 32'(s_tready), 32'd0);
    @(posedge clk); #1;
    check("t1_beat1", 32'({tlo, tdo, tle, tde}), 32'h1_07_1_00 >> 0 == 32'h1_07_1_00 ? {1'b1, 8'h07, 1'b1, 8'h00} : 18'h0);
    check("t1_ready_mid", 32'(s_tready), 32'd0);
    @(posedge clk); #1;
    check("t1_back_collect", 32'(s_tready), 32'd1);
    exp_odd.push_back({1'b0, 8'h01});
    exp_odd.push_back({1'b1, 8'h07});
    exp_even.push_back({1'b0, 8'h03});
    exp_even.push_back({1'b1, 8'h00});
    verify("t1");

    // Even-only packet
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    wait_idle("t2");
    exp_even.push_back({1'b0, 8'h11});
    exp_even.push_back({1'b1, 8'h22});
    verify("t2");

    // Forced split at a full buffer
    for (int i = 0; i < 9; i++) send(8'h01, (i == 8));
    wait_idle("t3");
    for (int i = 0; i < 7; i++) exp_odd.push_back({1'b0, 8'h01});
    exp_odd.push_back({1'b1, 8'h01});
    exp_odd.push_back({1'b1, 8'h01});
    verify("t3");

    // Back-pressure hold
    m_tready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t4_odd_hold", 32'({tvo, tlo, tdo}), 32'({1'b1, 1'b0, 8'h01}));
    check("t4_even_hold", 32'({tve, tle, tde}), 32'({1'b1, 1'b1, 8'h03}));
    check("t4_ready_hold", 32'(s_tready), 32'd0);
    m_tready = 1'b1;
    wait_idle("t4");
    exp_odd.push_back({1'b0, 8'h01});
    exp_odd.push_back({1'b1, 8'h02});
    exp_even.push_back({1'b1, 8'h03});
    verify("t4");

    // Reset mid-drain
    m_tready = 1'b0;
    send(8'h11, 1'b1);
    check("t5_pre_valid", 32'(tve), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_out", 32'({tvo, tve, tlo, tle, tdo, tde}), 32'd0);
    check("t5_rst_ready", 32'(s_tready), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    check("t5_ready", 32'({s_tready, tvo, tve}), 32'b100);
    m_tready = 1'b1;
    send(8'h07, 1'b0);
    send(8'h0F, 1'b1);
    wait_idle("t5");
    exp_odd.push_back({1'b1, 8'h07});
    exp_even.push_back({1'b1, 8'h0F});
    verify("t5");

    // Classification mode
    send(8'h03, 1'b0);
    send(8'h02, 1'b1);
    wait_idle("t6");
`ifdef DATA_PARITY_FILTER_LSB_MODE_EN
    exp_odd.push_back({1'b1, 8'h03});
    exp_even.push_back({1'b1, 8'h02});
`else
    exp_odd.push_back({1'b1, 8'h02});
    exp_even.push_back({1'b1, 8'h03});
`endif
    verify("t6");

    @(posedge clk); #1;
    check("ready_excl", viol_rdy, 32'd0);
    check("idle_zero", viol_zero, 32'd0);
    check("hold_stable", viol_hold, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
